led_counter_pwm: RTL and testbench
==================================

# led_counter_pwm

Parametrised button-driven signed saturating counter with PWM-dimmed LED display. Four raw push-buttons are synchronised, debounced and edge-detected; two step a WIDTH-bit signed counter, two step a five-level duty-cycle index. The counter value is shown on the LEDs, gated by a period-aligned PWM. It sits between the board button/LED pins and the top level, and generalises the fixed 4-bit lab counter/dimmer.

## Interface
- WIDTH, 4: counter and LED width in bits, range 2..16.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the debounced level changes (≥2).
- PWM_PERIOD, 100: PWM period in clk cycles (≥100).
- REPEAT_CYCLES, 16: auto-repeat interval in cycles; used only with AUTO_REPEAT_EN.
- clk  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-high reset: reset_n=1 at a rising edge resets all state.
- usr_btn  in  4  raw, asynchronous buttons. Bit 0 = counter −1, bit 1 = counter +1, bit 2 = duty −1, bit 3 = duty +1.
- usr_led  out  WIDTH  count bits AND pwm_signal, registered.
- pwm_signal  out  1  registered PWM output.
- duty_idx  out  3  current duty index, 0..4.
- count  out  WIDTH  signed counter value, two's complement.

## Operation
- Reset values:
  - count=0, duty_idx=4 (100 %), usr_led=0, pwm_signal=0.
  - PWM counter=0; all synchroniser, debounce and edge state cleared.
- Per button:
  - Two-flop synchroniser.
  - Debounce counter: increments while the synchronised level differs from the debounced level; clears when they match.
  - Debounced level flips when the counter reaches DEBOUNCE_CYCLES.
  - Press pulse = debounced rising edge, one cycle wide. Releases produce no pulse.
- Counter:
  - +1 pulse saturates at 2^(WIDTH−1)−1.
  - −1 pulse saturates at −2^(WIDTH−1).
  - +1 and −1 in the same cycle: no change.
- Duty index: levels 0..4 map to 5/25/50/75/100 %.
  - +1 pulse saturates at 4; −1 pulse saturates at 0.
  - +1 and −1 in the same cycle: no change.
  - Counter and duty pulses are independent and may apply in the same cycle.
- PWM:
  - pwm_cnt counts 0..PWM_PERIOD−1 and wraps.
  - Active threshold = pct[duty_idx]·PWM_PERIOD/100, integer division.
  - The threshold is latched only when pwm_cnt wraps to 0. A duty change never truncates a running period.
  - pwm_signal = (pwm_cnt < threshold), registered.
- Reset mid-operation (press in progress, mid-period): everything returns to reset values on that edge. A button still held after reset must re-debounce, so one pulse follows DEBOUNCE_CYCLES+2 cycles after reset deasserts.

## Timing
- Button latency: raw press first sampled at edge 0 → count/duty_idx update at edge DEBOUNCE_CYCLES+2.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no pulse.
- pwm_signal follows pwm_cnt by one cycle.
- usr_led follows count and pwm_signal by one cycle.
- A new duty takes effect at the next period start, up to PWM_PERIOD cycles after duty_idx changes.
- Throughput: at most one counter step and one duty step per cycle.

## Configuration
- AUTO_REPEAT_EN defined:
  - While a debounced button stays held, an extra press pulse fires REPEAT_CYCLES cycles after the initial pulse, then every REPEAT_CYCLES cycles.
  - Each button has its own repeat counter, cleared on release.
- AUTO_REPEAT_EN undefined:
  - Exactly one pulse per press regardless of hold time.
  - No repeat counters synthesised; REPEAT_CYCLES ignored.

## Structure
- Package led_counter_pwm_pkg holds:
  - Duty percent table {5,25,50,75,100}, NUM_LEVELS=5, reset duty index 4.
  - Button bit-index constants BTN_DEC_CNT=0, BTN_INC_CNT=1, BTN_DEC_PWM=2, BTN_INC_PWM=3.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; optional repeat under the macro) is instantiated four times. The top level holds the counter, duty index, PWM and output registers.

## Test plan
- Defaults, reset 5 cycles, then 8 separate +1 presses (each held 50 cycles, released 50) → count 1..7 then stays 7; LEDs show 0111 during high PWM.
- 16 separate −1 presses from 7 → count steps to −8 (1000) and stays at −8; one +1 press → −7.
- Duty −1 ×5 from reset → duty_idx 3,2,1,0,0; high time per 100-cycle period 75,50,25,5,5. Duty +1 ×2 → idx 2, 50 high cycles starting at the next period.
- 3-cycle glitch on bit 1 → no count change. Hold 4+ cycles → exactly one step, visible 6 cycles after the first sample.
- Bits 0 and 1 pressed together → count unchanged. Bits 1 and 3 together → count+1 and duty+1 on the same cycle.
- Assert reset while a button is held, mid-period → all outputs return to reset values next edge. With AUTO_REPEAT_EN, a 100-cycle hold → 1+⌊(held cycles after first pulse)/16⌋ steps.

Source files
------------

// File: rtl/led_counter_pwm_pkg.sv
// led_counter_pwm_pkg: shared constants and helpers for the button-driven
// saturating counter with PWM-dimmed LED display.
package led_counter_pwm_pkg;

    // Number of selectable duty levels and the index range they span
    localparam int          NUM_LEVELS     = 5;
    localparam logic [2:0]  DUTY_MAX_IDX   = 3'(NUM_LEVELS - 1);
    localparam logic [2:0]  DUTY_RESET_IDX = 3'd4;

    // Button bit positions inside usr_btn
    localparam int BTN_DEC_CNT = 0;
    localparam int BTN_INC_CNT = 1;
    localparam int BTN_DEC_PWM = 2;
    localparam int BTN_INC_PWM = 3;

    // Duty percentage for each level: 5/25/50/75/100 %
    function automatic int unsigned duty_pct(input logic [2:0] idx);
        int unsigned pct;
        case (idx)
            3'd0:    pct = 32'd5;
            3'd1:    pct = 32'd25;
            3'd2:    pct = 32'd50;
            3'd3:    pct = 32'd75;
            3'd4:    pct = 32'd100;
            default: pct = 32'd0;
        endcase
        return pct;
    endfunction

    // Number of high cycles per PWM period for a level (integer division)
    function automatic int unsigned duty_threshold(input logic [2:0]  idx,
                                                   input int unsigned period);
        return (duty_pct(idx) * period) / 32'd100;
    endfunction

endpackage

// File: rtl/led_counter_pwm_btn_debounce.sv
// btn_debounce: two-flop synchroniser, stable-level debouncer and press
// (rising-edge) pulse generator for one raw push-button.
// Optional auto-repeat of the press pulse while held: define AUTO_REPEAT_EN.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 16
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          deb_r;
    logic          deb_d_r;
    logic [DW-1:0] deb_cnt_r;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk) begin
        if (reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive differing cycles; the level flips on the
    // DEBOUNCE_CYCLES-th one, so a raw edge lands in deb_r after D+1 edges
    always_ff @(posedge clk) begin
        if (reset_n) begin
            deb_r     <= 1'b0;
            deb_cnt_r <= DW'(0);
        end else if (sync2_r != deb_r) begin
            if (deb_cnt_r == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_r     <= sync2_r;
                deb_cnt_r <= DW'(0);
            end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
            end
        end else begin
            deb_cnt_r <= DW'(0);
        end
    end

    // Previous debounced level for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset_n) begin
            deb_d_r <= 1'b0;
        end else begin
            deb_d_r <= deb_r;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] rep_cnt_r;

    // Phase counter while held: returns to zero every REPEAT_CYCLES cycles
    // after the initial press, cleared on release
    always_ff @(posedge clk) begin
        if (reset_n) begin
            rep_cnt_r <= RW'(0);
        end else if (!deb_r) begin
            rep_cnt_r <= RW'(0);
        end else if (rep_cnt_r == RW'(REPEAT_CYCLES - 1)) begin
            rep_cnt_r <= RW'(0);
        end else begin
            rep_cnt_r <= rep_cnt_r + RW'(1);
        end
    end

    assign press = deb_r & (~deb_d_r | (rep_cnt_r == RW'(0)));
`else
    assign press = deb_r & ~deb_d_r;
`endif

endmodule

// File: rtl/led_counter_pwm.sv
// led_counter_pwm: four debounced buttons step a WIDTH-bit signed saturating
// counter and a five-level duty index; the counter drives the LEDs gated by a
// period-aligned PWM. Optional button auto-repeat: define AUTO_REPEAT_EN.
module led_counter_pwm
    import led_counter_pwm_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PWM_PERIOD      = 100,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [3:0]              usr_btn,
    output logic [WIDTH-1:0]        usr_led,
    output logic                    pwm_signal,
    output logic [2:0]              duty_idx,
    output logic signed [WIDTH-1:0] count
);

    localparam int CW = $clog2(PWM_PERIOD);
    localparam int TW = $clog2(PWM_PERIOD + 1);

    localparam logic signed [WIDTH-1:0] CNT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] CNT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [TW-1:0] THRESH_RESET =
        TW'(duty_threshold(DUTY_RESET_IDX, $unsigned(PWM_PERIOD)));

    // Reject parameter values outside the supported range at elaboration
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("led_counter_pwm: WIDTH must be 2..16");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("led_counter_pwm: DEBOUNCE_CYCLES must be >= 2");
    end
    if (PWM_PERIOD < 100) begin : g_bad_period
        $error("led_counter_pwm: PWM_PERIOD must be >= 100");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("led_counter_pwm: REPEAT_CYCLES must be >= 1");
    end

    logic [3:0]              press_s;
    logic                    inc_cnt_s;
    logic                    dec_cnt_s;
    logic                    inc_pwm_s;
    logic                    dec_pwm_s;
    logic signed [WIDTH-1:0] count_r;
    logic signed [WIDTH-1:0] count_next_s;
    logic [2:0]              duty_idx_r;
    logic [2:0]              duty_next_s;
    logic [CW-1:0]           pwm_cnt_r;
    logic                    pwm_wrap_s;
    logic [TW-1:0]           thresh_r;
    logic [TW-1:0]           thresh_next_s;
    logic                    pwm_signal_r;
    logic [WIDTH-1:0]        usr_led_r;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
            ,
            .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .btn_raw (usr_btn[i]),
            .press   (press_s[i])
        );
    end

    assign dec_cnt_s = press_s[BTN_DEC_CNT];
    assign inc_cnt_s = press_s[BTN_INC_CNT];
    assign dec_pwm_s = press_s[BTN_DEC_PWM];
    assign inc_pwm_s = press_s[BTN_INC_PWM];

    // Saturating counter step; opposing presses in one cycle cancel
    always_comb begin
        count_next_s = count_r;
        case ({inc_cnt_s, dec_cnt_s})
            2'b10: begin
                if (count_r != CNT_MAX) begin
                    count_next_s = count_r + WIDTH'(1);
                end else begin
                    count_next_s = count_r;
                end
            end
            2'b01: begin
                if (count_r != CNT_MIN) begin
                    count_next_s = count_r - WIDTH'(1);
                end else begin
                    count_next_s = count_r;
                end
            end
            default: count_next_s = count_r;
        endcase
    end

    // Saturating duty index step; opposing presses in one cycle cancel
    always_comb begin
        duty_next_s = duty_idx_r;
        case ({inc_pwm_s, dec_pwm_s})
            2'b10: begin
                if (duty_idx_r != DUTY_MAX_IDX) begin
                    duty_next_s = duty_idx_r + 3'd1;
                end else begin
                    duty_next_s = duty_idx_r;
                end
            end
            2'b01: begin
                if (duty_idx_r != 3'd0) begin
                    duty_next_s = duty_idx_r - 3'd1;
                end else begin
                    duty_next_s = duty_idx_r;
                end
            end
            default: duty_next_s = duty_idx_r;
        endcase
    end

    // Counter and duty index state
    always_ff @(posedge clk) begin
        if (reset_n) begin
            count_r    <= WIDTH'(0);
            duty_idx_r <= DUTY_RESET_IDX;
        end else begin
            count_r    <= count_next_s;
            duty_idx_r <= duty_next_s;
        end
    end

    assign pwm_wrap_s    = (pwm_cnt_r == CW'(PWM_PERIOD - 1));
    assign thresh_next_s = TW'(duty_threshold(duty_idx_r, $unsigned(PWM_PERIOD)));

    // Free-running period counter 0..PWM_PERIOD-1
    always_ff @(posedge clk) begin
        if (reset_n) begin
            pwm_cnt_r <= CW'(0);
        end else if (pwm_wrap_s) begin
            pwm_cnt_r <= CW'(0);
        end else begin
            pwm_cnt_r <= pwm_cnt_r + CW'(1);
        end
    end

    // Threshold only reloads at the period boundary so a duty change
    // never cuts a running period short
    always_ff @(posedge clk) begin
        if (reset_n) begin
            thresh_r <= THRESH_RESET;
        end else if (pwm_wrap_s) begin
            thresh_r <= thresh_next_s;
        end else begin
            thresh_r <= thresh_r;
        end
    end

    // Registered PWM compare and LED gating
    always_ff @(posedge clk) begin
        if (reset_n) begin
            pwm_signal_r <= 1'b0;
            usr_led_r    <= WIDTH'(0);
        end else begin
            pwm_signal_r <= (TW'(pwm_cnt_r) < thresh_r);
            if (pwm_signal_r) begin
                usr_led_r <= count_r;
            end else begin
                usr_led_r <= WIDTH'(0);
            end
        end
    end

    assign count      = count_r;
    assign duty_idx   = duty_idx_r;
    assign pwm_signal = pwm_signal_r;
    assign usr_led    = usr_led_r;

endmodule

// File: tb/tb_led_counter_pwm.sv
// tb_led_counter_pwm: directed self-checking bench for led_counter_pwm
// (default parameters, AUTO_REPEAT_EN undefined).
module tb_led_counter_pwm;

    logic              clk;
    logic              reset_n;
    logic [3:0]        usr_btn;
    logic [3:0]        usr_led;
    logic              pwm_signal;
    logic [2:0]        duty_idx;
    logic signed [3:0] count;

    int n_tests;
    int n_fail;

    led_counter_pwm #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .PWM_PERIOD      (100),
        .REPEAT_CYCLES   (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .usr_btn    (usr_btn),
        .usr_led    (usr_led),
        .pwm_signal (pwm_signal),
        .duty_idx   (duty_idx),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic press(input logic [3:0] mask, input int hold, input int rel);
        @(negedge clk);
        usr_btn = mask;
        repeat (hold) @(negedge clk);
        usr_btn = 4'b0000;
        repeat (rel) @(negedge clk);
    endtask

    task automatic measure_high(output int highs);
        highs = 0;
        repeat (100) begin
            @(negedge clk);
            if (pwm_signal) highs++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        usr_btn = 4'b0000;
        repeat (5) @(negedge clk);
        n_tests++; if (count !== 4'sd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (duty_idx !== 3'd4) begin n_fail++; $display("FAIL reset_duty: got %0d expected 4", duty_idx); end
        n_tests++; if (usr_led !== 4'b0000) begin n_fail++; $display("FAIL reset_led: got %b expected 0000", usr_led); end
        n_tests++; if (pwm_signal !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b expected 0", pwm_signal); end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_inc_saturate;
        int exp_v;
        exp_v = 0;
        for (int i = 1; i <= 8; i++) begin
            press(4'b0010, 50, 50);
            exp_v = (exp_v < 7) ? exp_v + 1 : 7;
            n_tests++;
            if (count !== 4'(exp_v)) begin
                n_fail++; $display("FAIL inc_press_%0d: got %0d expected %0d", i, count, exp_v);
            end
        end
        n_tests++; if (pwm_signal !== 1'b1) begin n_fail++; $display("FAIL pwm_full: got %b expected 1", pwm_signal); end
        n_tests++; if (usr_led !== 4'b0111) begin n_fail++; $display("FAIL led_max: got %b expected 0111", usr_led); end
    endtask

    task automatic test_dec_saturate;
        int exp_v;
        exp_v = 7;
        for (int i = 1; i <= 16; i++) begin
            press(4'b0001, 50, 50);
            exp_v = (exp_v > -8) ? exp_v - 1 : -8;
            n_tests++;
            if (count !== 4'(exp_v)) begin
                n_fail++; $display("FAIL dec_press_%0d: got %0d expected %0d", i, count, exp_v);
            end
        end
        n_tests++; if (usr_led !== 4'b1000) begin n_fail++; $display("FAIL led_min: got %b expected 1000", usr_led); end
        press(4'b0010, 50, 50);
        n_tests++; if (count !== -4'sd7) begin n_fail++; $display("FAIL inc_from_min: got %0d expected -7", count); end
    endtask

    task automatic test_glitch_latency;
        logic signed [3:0] c0;
        c0 = count;
        @(negedge clk);
        usr_btn = 4'b0010;
        repeat (3) @(negedge clk);
        usr_btn = 4'b0000;
        repeat (20) @(negedge clk);
        n_tests++; if (count !== c0) begin n_fail++; $display("FAIL glitch: got %0d expected %0d", count, c0); end
        @(negedge clk);
        usr_btn = 4'b0010;
        repeat (6) @(negedge clk);
        n_tests++; if (count !== c0) begin n_fail++; $display("FAIL latency_early: got %0d expected %0d", count, c0); end
        @(negedge clk);
        n_tests++; if (count !== c0 + 4'sd1) begin n_fail++; $display("FAIL latency_edge6: got %0d expected %0d", count, c0 + 4'sd1); end
        repeat (40) @(negedge clk);
        usr_btn = 4'b0000;
        repeat (50) @(negedge clk);
        n_tests++; if (count !== c0 + 4'sd1) begin n_fail++; $display("FAIL single_step: got %0d expected %0d", count, c0 + 4'sd1); end
    endtask

    task automatic test_duty;
        logic [2:0] exp_idx [5];
        int         exp_hi  [5];
        int         highs;
        exp_idx = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        exp_hi  = '{75, 50, 25, 5, 5};
        for (int i = 0; i < 5; i++) begin
            press(4'b0100, 50, 50);
            n_tests++;
            if (duty_idx !== exp_idx[i]) begin
                n_fail++; $display("FAIL duty_dec_idx_%0d: got %0d expected %0d", i, duty_idx, exp_idx[i]);
            end
            repeat (200) @(negedge clk);
            measure_high(highs);
            n_tests++;
            if (highs !== exp_hi[i]) begin
                n_fail++; $display("FAIL duty_dec_high_%0d: got %0d expected %0d", i, highs, exp_hi[i]);
            end
        end
        press(4'b1000, 50, 50);
        press(4'b1000, 50, 50);
        n_tests++; if (duty_idx !== 3'd2) begin n_fail++; $display("FAIL duty_inc_idx: got %0d expected 2", duty_idx); end
        repeat (200) @(negedge clk);
        measure_high(highs);
        n_tests++; if (highs !== 50) begin n_fail++; $display("FAIL duty_inc_high: got %0d expected 50", highs); end
    endtask

    task automatic test_simultaneous;
        logic signed [3:0] c0;
        c0 = count;
        press(4'b0011, 50, 50);
        n_tests++; if (count !== c0) begin n_fail++; $display("FAIL inc_dec_cancel: got %0d expected %0d", count, c0); end
        @(negedge clk);
        usr_btn = 4'b1010;
        repeat (6) @(negedge clk);
        n_tests++; if (duty_idx !== 3'd2) begin n_fail++; $display("FAIL both_duty_early: got %0d expected 2", duty_idx); end
        @(negedge clk);
        n_tests++; if (count !== c0 + 4'sd1) begin n_fail++; $display("FAIL both_count: got %0d expected %0d", count, c0 + 4'sd1); end
        n_tests++; if (duty_idx !== 3'd3) begin n_fail++; $display("FAIL both_duty: got %0d expected 3", duty_idx); end
        usr_btn = 4'b0000;
        repeat (50) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        usr_btn = 4'b0010;
        repeat (30) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++; if (count !== 4'sd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", count); end
        n_tests++; if (duty_idx !== 3'd4) begin n_fail++; $display("FAIL mid_reset_duty: got %0d expected 4", duty_idx); end
        n_tests++; if (usr_led !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_led: got %b expected 0000", usr_led); end
        n_tests++; if (pwm_signal !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pwm: got %b expected 0", pwm_signal); end
        reset_n = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++; if (count !== 4'sd0) begin n_fail++; $display("FAIL held_after_reset_early: got %0d expected 0", count); end
        @(negedge clk);
        n_tests++; if (count !== 4'sd1) begin n_fail++; $display("FAIL held_after_reset: got %0d expected 1", count); end
        usr_btn = 4'b0000;
        repeat (50) @(negedge clk);
        n_tests++; if (count !== 4'sd1) begin n_fail++; $display("FAIL held_after_reset_once: got %0d expected 1", count); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b1;
        usr_btn = 4'b0000;
        test_reset();
        test_inc_saturate();
        test_dec_saturate();
        test_glitch_latency();
        test_duty();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
